// File: rtl/cv32e40p_pkg.sv
// Shared types for the instruction fetch path.
package cv32e40p_pkg;

    // Fetch FSM: BRANCH_WAIT holds a stale ungranted request until it is granted.
    typedef enum logic [0:0] {
        FETCH_IDLE        = 1'b0,
        FETCH_BRANCH_WAIT = 1'b1
    } fetch_state_e;

    // One buffered OBI response: read data plus its bus error flag.
    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } fetch_entry_t;

    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/cv32e40p_fetch_fifo.sv
// Response buffer for the fetch unit: strict FIFO of {err, rdata} entries with flush.
module cv32e40p_fetch_fifo
    import cv32e40p_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic               push_i,
    input  fetch_entry_t       push_data_i,
    input  logic               pop_i,
    output fetch_entry_t       pop_data_o,
    output logic [CNT_W-1:0]   count_o,
    output logic               empty_o,
    output logic               full_o
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o    = (cnt_q == '0);
    assign full_o     = (cnt_q == CNT_W'(DEPTH));
    assign count_o    = cnt_q;
    assign pop_data_o = mem_q[rptr_q];

    // Pointer and occupancy update; flush wins over push/pop.
    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        cnt_d   = cnt_q;
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        if (flush_i) begin
            rptr_d = '0;
            wptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (do_push) begin
                wptr_d = wptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rptr_d = rptr_q + PTR_W'(1);
            end
            cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage array; contents are only observed through a non-empty FIFO.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/cv32e40p_obi_fetch_unit.sv
// Instruction-side OBI master: issues word fetches, tracks outstanding
// transactions, drops stale responses after a branch and delivers words.
module cv32e40p_obi_fetch_unit
    import cv32e40p_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH      = 2,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter bit          PULP_OBI        = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    output logic        fetch_valid_o,
    input  logic        fetch_ready_i,
    output logic [31:0] fetch_rdata_o,
    output logic        fetch_err_o,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    output logic        busy_o
);

    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 2);
    localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);

    fetch_state_e      state_q, state_d;
    logic              armed_q, armed_d;
    logic              hold_q, hold_d;
    logic [31:0]       next_addr_q, next_addr_d;
    logic [31:0]       stale_addr_q, stale_addr_d;
    logic [CNT_W-1:0]  out_q, out_d;
    logic [CNT_W-1:0]  discard_q, discard_d;

    logic              req_c;
    logic [31:0]       addr_c;
    logic              gnt_hs;
    logic              credit_ok;
    logic              enter_bw;
    logic              stale_pending;
    logic              resp_keep;
    logic              bypass;
    logic              valid_c;
    fetch_entry_t      resp_entry;
    fetch_entry_t      out_entry;

    logic              fifo_push;
    logic              fifo_pop;
    fetch_entry_t      fifo_rdata;
    logic [FCNT_W-1:0] fifo_count;
    logic              fifo_empty;
    logic              fifo_full;

    // Request/address generation, branch handling, credit and delivery logic.
    always_comb begin
        state_d       = state_q;
        armed_d       = armed_q || branch_i;
        next_addr_d   = next_addr_q;
        stale_addr_d  = stale_addr_q;
        discard_d     = discard_q;
        req_c         = 1'b0;
        addr_c        = next_addr_q;
        enter_bw      = 1'b0;
        stale_pending = 1'b0;

        credit_ok = (out_q < CNT_W'(MAX_OUTSTANDING)) &&
                    (((CNT_W+1)'(out_q) + (CNT_W+1)'(fifo_count)) < (CNT_W+1)'(FIFO_DEPTH));

        if (state_q == FETCH_BRANCH_WAIT) begin
            req_c  = 1'b1;
            addr_c = stale_addr_q;
        end else begin
            // A pending ungranted request stays up unless legacy mode lets a branch retract it.
            req_c = (hold_q && !(PULP_OBI && branch_i)) ||
                    (armed_q && req_i && !branch_i && credit_ok);
        end
        gnt_hs = req_c && instr_gnt_i;

        enter_bw = !PULP_OBI && branch_i && (state_q == FETCH_IDLE) && hold_q && !instr_gnt_i;
        stale_pending = enter_bw || ((state_q == FETCH_BRANCH_WAIT) && !instr_gnt_i);

        if (state_q == FETCH_BRANCH_WAIT) begin
            if (instr_gnt_i) begin
                state_d = FETCH_IDLE;
            end
        end else if (enter_bw) begin
            state_d      = FETCH_BRANCH_WAIT;
            stale_addr_d = next_addr_q;
        end

        // Only grants of the live stream advance the fetch address.
        if ((state_q == FETCH_IDLE) && gnt_hs) begin
            next_addr_d = next_addr_q + WORD_BYTES;
        end
        if (branch_i) begin
            next_addr_d = branch_addr_i & WORD_ALIGN_MASK;
        end

        out_d = out_q + CNT_W'(gnt_hs) - CNT_W'(instr_rvalid_i);

        if (branch_i) begin
            discard_d = out_d + CNT_W'(stale_pending);
        end else if (instr_rvalid_i && (discard_q != '0)) begin
            discard_d = discard_q - CNT_W'(1);
        end

        resp_keep = instr_rvalid_i && !branch_i && (discard_q == '0);
        bypass    = resp_keep && fifo_empty && fetch_ready_i;
        fifo_push = resp_keep && !bypass;
        fifo_pop  = !branch_i && !fifo_empty && fetch_ready_i;
        valid_c   = !branch_i && (!fifo_empty || resp_keep);

        resp_entry.err   = instr_err_i;
        resp_entry.rdata = instr_rdata_i;
        out_entry        = fifo_empty ? resp_entry : fifo_rdata;
        if (!valid_c) begin
            out_entry = '0;
        end

        hold_d = (state_d == FETCH_IDLE) && req_c && !instr_gnt_i;
    end

    // State, address and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FETCH_IDLE;
            armed_q      <= 1'b0;
            hold_q       <= 1'b0;
            next_addr_q  <= '0;
            stale_addr_q <= '0;
            out_q        <= '0;
            discard_q    <= '0;
        end else begin
            state_q      <= state_d;
            armed_q      <= armed_d;
            hold_q       <= hold_d;
            next_addr_q  <= next_addr_d;
            stale_addr_q <= stale_addr_d;
            out_q        <= out_d;
            discard_q    <= discard_d;
        end
    end

    cv32e40p_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (branch_i),
        .push_i      (fifo_push),
        .push_data_i (resp_entry),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_rdata),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    assign instr_req_o   = req_c;
    assign instr_addr_o  = addr_c;
    assign fetch_valid_o = valid_c;
    assign fetch_rdata_o = out_entry.rdata;
    assign fetch_err_o   = out_entry.err;
    assign busy_o        = req_c || (out_q != '0);

    // The credit rule must keep a response from ever landing on a full FIFO.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_cv32e40p_obi_fetch_unit.sv
// Bench for the OBI fetch unit: directed branches/backpressure with queued expectations.
module tb_cv32e40p_obi_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i;
    logic        branch_i;
    logic [31:0] branch_addr_i;
    logic        fetch_valid_o;
    logic        fetch_ready_i;
    logic [31:0] fetch_rdata_o;
    logic        fetch_err_o;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i = 1'b0;
    logic [31:0] instr_rdata_i  = 32'h0;
    logic        instr_err_i    = 1'b0;
    logic        busy_o;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_addr [$];
    logic [32:0] exp_data [$];
    logic [31:0] pend     [$];
    logic        rsp_en   = 1'b1;
    logic [31:0] err_addr = 32'h0000_4004;

    always #5 clk = ~clk;

    cv32e40p_obi_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .req_i          (req_i),
        .branch_i       (branch_i),
        .branch_addr_i  (branch_addr_i),
        .fetch_valid_o  (fetch_valid_o),
        .fetch_ready_i  (fetch_ready_i),
        .fetch_rdata_o  (fetch_rdata_o),
        .fetch_err_o    (fetch_err_o),
        .instr_req_o    (instr_req_o),
        .instr_addr_o   (instr_addr_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .instr_err_i    (instr_err_i),
        .busy_o         (busy_o)
    );

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_word(input logic [31:0] addr, input logic err);
        exp_addr.push_back(addr);
        exp_data.push_back({err, addr ^ 32'hDEAD_0000});
    endtask

    // Memory slave: answers in order, one cycle after grant, data = addr ^ 0xDEAD0000.
    always @(posedge clk) begin
        #2;
        if (!rst && rsp_en && pend.size() > 0) begin
            instr_rvalid_i = 1'b1;
            instr_rdata_i  = pend[0] ^ 32'hDEAD_0000;
            instr_err_i    = (pend[0] == err_addr);
        end else begin
            instr_rvalid_i = 1'b0;
            instr_rdata_i  = 32'h0;
            instr_err_i    = 1'b0;
        end
    end

    // Monitor: compares every grant address and every accepted word against the queues.
    always @(negedge clk) begin
        if (rst) begin
            pend.delete();
        end else begin
            if (fetch_valid_o && fetch_ready_i) begin
                if (exp_data.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got %h expected none at %0t", fetch_rdata_o, $time);
                end else begin
                    check("fetch_word", {fetch_err_o, fetch_rdata_o}, exp_data.pop_front());
                end
            end
            if (instr_rvalid_i && pend.size() > 0) begin
                void'(pend.pop_front());
            end
            if (instr_req_o && instr_gnt_i) begin
                if (exp_addr.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_grant: got %h expected none at %0t", instr_addr_o, $time);
                end else begin
                    check("grant_addr", {1'b0, instr_addr_o}, {1'b0, exp_addr.pop_front()});
                end
                pend.push_back(instr_addr_o);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        req_i         = 1'b1;
        branch_i      = 1'b0;
        branch_addr_i = 32'h0;
        fetch_ready_i = 1'b1;
        instr_gnt_i   = 1'b1;

        // Reset state.
        #12;
        check("rst_req",   {32'h0, instr_req_o},   33'h0);
        check("rst_addr",  {1'b0, instr_addr_o},   33'h0);
        check("rst_valid", {32'h0, fetch_valid_o}, 33'h0);
        check("rst_rdata", {1'b0, fetch_rdata_o},  33'h0);
        check("rst_err",   {32'h0, fetch_err_o},   33'h0);
        check("rst_busy",  {32'h0, busy_o},        33'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Not armed: no request even with req_i high.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("unarmed_req", {32'h0, instr_req_o}, 33'h0);
            cyc(1);
        end

        // Boot redirect to 0x1082 -> word stream from 0x1080.
        push_word(32'h1080, 1'b0);
        push_word(32'h1084, 1'b0);
        push_word(32'h1088, 1'b0);
        push_word(32'h108C, 1'b0);
        branch_i      = 1'b1;
        branch_addr_i = 32'h0000_1082;
        @(negedge clk);
        check("boot_br_req",   {32'h0, instr_req_o},   33'h0);
        check("boot_br_valid", {32'h0, fetch_valid_o}, 33'h0);
        cyc(1);
        branch_i = 1'b0;
        @(negedge clk);
        check("boot_req",    {32'h0, instr_req_o},   33'h1);
        check("boot_addr",   {1'b0, instr_addr_o},   {1'b0, 32'h1080});
        check("boot_valid1", {32'h0, fetch_valid_o}, 33'h0);
        cyc(1);
        @(negedge clk);
        check("boot_valid2", {32'h0, fetch_valid_o}, 33'h1);
        cyc(3);
        req_i = 1'b0;
        cyc(5);

        // Backpressure: two grants fill the buffer, then requests stop.
        push_word(32'h1090, 1'b0);
        push_word(32'h1094, 1'b0);
        push_word(32'h1098, 1'b0);
        push_word(32'h109C, 1'b0);
        fetch_ready_i = 1'b0;
        req_i         = 1'b1;
        cyc(5);
        @(negedge clk);
        check("bp_req",   {32'h0, instr_req_o},   33'h0);
        check("bp_valid", {32'h0, fetch_valid_o}, 33'h1);
        check("bp_head",  {1'b0, fetch_rdata_o},  {1'b0, 32'hDEAD_1090});
        cyc(1);
        fetch_ready_i = 1'b1;
        cyc(3);
        req_i = 1'b0;
        cyc(5);

        // Branch while a request to 0x2000 is stalled.
        push_word(32'h3000, 1'b0);
        push_word(32'h3004, 1'b0);
        exp_addr.push_front(32'h2000);
        instr_gnt_i   = 1'b0;
        branch_i      = 1'b1;
        branch_addr_i = 32'h0000_2000;
        req_i         = 1'b1;
        cyc(1);
        branch_i = 1'b0;
        @(negedge clk);
        check("stall_req",  {32'h0, instr_req_o}, 33'h1);
        check("stall_addr", {1'b0, instr_addr_o}, {1'b0, 32'h2000});
        cyc(1);
        req_i = 1'b0;
        @(negedge clk);
        check("stall_hold_req",  {32'h0, instr_req_o}, 33'h1);
        check("stall_hold_addr", {1'b0, instr_addr_o}, {1'b0, 32'h2000});
        cyc(1);
        req_i         = 1'b1;
        branch_i      = 1'b1;
        branch_addr_i = 32'h0000_3000;
        @(negedge clk);
        check("bw_br_addr", {1'b0, instr_addr_o}, {1'b0, 32'h2000});
        check("bw_br_req",  {32'h0, instr_req_o}, 33'h1);
        cyc(1);
        branch_i = 1'b0;
        @(negedge clk);
        check("bw_wait_addr", {1'b0, instr_addr_o}, {1'b0, 32'h2000});
        cyc(1);
        instr_gnt_i = 1'b1;
        @(negedge clk);
        check("bw_gnt_addr", {1'b0, instr_addr_o}, {1'b0, 32'h2000});
        cyc(1);
        @(negedge clk);
        check("bw_new_addr", {1'b0, instr_addr_o},   {1'b0, 32'h3000});
        check("bw_drop",     {32'h0, fetch_valid_o}, 33'h0);
        cyc(2);
        req_i = 1'b0;
        cyc(5);

        // Branch with two responses in flight, one returning in the branch cycle.
        exp_addr.push_back(32'h3008);
        exp_addr.push_back(32'h300C);
        push_word(32'h5000, 1'b0);
        push_word(32'h5004, 1'b0);
        rsp_en = 1'b0;
        req_i  = 1'b1;
        cyc(2);
        branch_i      = 1'b1;
        branch_addr_i = 32'h0000_5000;
        rsp_en        = 1'b1;
        @(negedge clk);
        check("fl_busy",  {32'h0, busy_o},        33'h1);
        check("fl_valid", {32'h0, fetch_valid_o}, 33'h0);
        cyc(1);
        branch_i = 1'b0;
        @(negedge clk);
        check("fl_drop2", {32'h0, fetch_valid_o}, 33'h0);
        check("fl_addr",  {1'b0, instr_addr_o},   {1'b0, 32'h5000});
        cyc(2);
        req_i = 1'b0;
        cyc(5);

        // Error flag travels only with the 0x4004 word.
        push_word(32'h4000, 1'b0);
        push_word(32'h4004, 1'b1);
        push_word(32'h4008, 1'b0);
        branch_i      = 1'b1;
        branch_addr_i = 32'h0000_4000;
        req_i         = 1'b1;
        cyc(1);
        branch_i = 1'b0;
        cyc(3);
        req_i = 1'b0;
        cyc(5);

        // Reset with two transactions outstanding.
        exp_addr.push_back(32'h6000);
        exp_addr.push_back(32'h6004);
        rsp_en        = 1'b0;
        branch_i      = 1'b1;
        branch_addr_i = 32'h0000_6000;
        req_i         = 1'b1;
        cyc(1);
        branch_i = 1'b0;
        cyc(2);
        @(negedge clk);
        check("mr_busy", {32'h0, busy_o},      33'h1);
        check("mr_req",  {32'h0, instr_req_o}, 33'h0);
        cyc(1);
        rst = 1'b1;
        #1;
        check("mr_rst_req",   {32'h0, instr_req_o},   33'h0);
        check("mr_rst_addr",  {1'b0, instr_addr_o},   33'h0);
        check("mr_rst_valid", {32'h0, fetch_valid_o}, 33'h0);
        check("mr_rst_rdata", {1'b0, fetch_rdata_o},  33'h0);
        check("mr_rst_err",   {32'h0, fetch_err_o},   33'h0);
        check("mr_rst_busy",  {32'h0, busy_o},        33'h0);
        cyc(2);
        rst    = 1'b0;
        rsp_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mr_unarmed_req", {32'h0, instr_req_o}, 33'h0);
            cyc(1);
        end
        push_word(32'h7000, 1'b0);
        branch_i      = 1'b1;
        branch_addr_i = 32'h0000_7002;
        cyc(1);
        branch_i = 1'b0;
        cyc(1);
        req_i = 1'b0;
        cyc(5);

        check("addr_queue_drained", 33'(exp_addr.size()), 33'h0);
        check("data_queue_drained", 33'(exp_data.size()), 33'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
